// File: rtl/recv_buffer_if.sv
// recv_buffer_if: byte stream bundle between the UART receiver side,
// the receive FIFO and the consuming core.
//   in_data/in_valid : receiver byte strobe (no backpressure)
//   flush            : synchronous clear on mode switch
//   out_data/out_valid/out_ready : FWFT head byte with pop handshake
//   overrun/overrun_cnt          : dropped-byte status
// master = producer/consumer side, slave = the FIFO.
interface recv_buffer_if #(
    parameter int OVERRUN_WIDTH = 8
);
    logic [7:0]               in_data;
    logic                     in_valid;
    logic                     flush;
    logic [7:0]               out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     overrun;
    logic [OVERRUN_WIDTH-1:0] overrun_cnt;

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  out_data, out_valid, overrun, overrun_cnt
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output out_data, out_valid, overrun, overrun_cnt
    );
endinterface

// File: rtl/recv_buffer.sv
// recv_buffer: 2**DEPTH_WIDTH x 8 first-word-fall-through byte FIFO
// between the UART receiver and the core.
//   CLK, RST_N  : clock, asynchronous active-low reset
//   bus (slave) : in_data/in_valid push, out_data/out_valid/out_ready pop,
//                 flush, overrun (sticky) and overrun_cnt (saturating)
// Optional macro RECV_BUFFER_LEVEL_EN adds ports:
//   level       : current fill count (DEPTH_WIDTH+1 bits)
//   almost_full : count >= depth - 2
module recv_buffer #(
    parameter int DEPTH_WIDTH   = 4,
    parameter int OVERRUN_WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    recv_buffer_if.slave     bus
`ifdef RECV_BUFFER_LEVEL_EN
    ,
    output logic [DEPTH_WIDTH:0] level,
    output logic                 almost_full
`endif
);
    localparam int DEPTH = 2 ** DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] FULL_CNT = (DEPTH_WIDTH + 1)'(DEPTH);

    logic [7:0]               r_mem [DEPTH];
    logic [DEPTH_WIDTH-1:0]   r_wr_ptr;
    logic [DEPTH_WIDTH-1:0]   r_rd_ptr;
    logic [DEPTH_WIDTH:0]     r_count;
    logic [7:0]               r_out_data;
    logic                     r_overrun;
    logic [OVERRUN_WIDTH-1:0] r_ovr_cnt;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_drop;
    logic                     w_bypass;
    logic [DEPTH_WIDTH-1:0]   w_rd_next;
    logic [7:0]               w_next_data;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = bus.out_ready && !w_empty;
    // A pop on a full FIFO frees the slot the incoming byte lands in.
    assign w_push  = bus.in_valid && (!w_full || w_pop);
    assign w_drop  = bus.in_valid && w_full && !w_pop;

    assign w_rd_next = r_rd_ptr + DEPTH_WIDTH'(w_pop);
    // When the FIFO is empty after this cycle's pop, the new head is the
    // byte being written right now, which is not yet in r_mem.
    assign w_bypass    = w_push && (r_count == {{DEPTH_WIDTH{1'b0}}, w_pop});
    assign w_next_data = w_bypass ? bus.in_data : r_mem[w_rd_next];

    always_ff @(posedge CLK) begin
        if (w_push && !bus.flush) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= '0;
            r_overrun  <= 1'b0;
            r_ovr_cnt  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= '0;
            r_overrun  <= 1'b0;
            r_ovr_cnt  <= '0;
        end else begin
            r_out_data <= w_next_data;
            r_rd_ptr   <= w_rd_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overrun <= 1'b1;
                if (r_ovr_cnt != '1) begin
                    r_ovr_cnt <= r_ovr_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = !w_empty;
    assign bus.overrun     = r_overrun;
    assign bus.overrun_cnt = r_ovr_cnt;

`ifdef RECV_BUFFER_LEVEL_EN
    assign level       = r_count;
    assign almost_full = (r_count >= FULL_CNT - 2'd2);
`endif
endmodule

// File: tb/tb_recv_buffer.sv
module tb_recv_buffer;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    recv_buffer_if #(.OVERRUN_WIDTH(8)) bus ();

`ifdef RECV_BUFFER_LEVEL_EN
    logic [4:0] level;
    logic       almost_full;
`endif

    recv_buffer #(.DEPTH_WIDTH(4), .OVERRUN_WIDTH(8)) u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
`ifdef RECV_BUFFER_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic do_flush();
        idle();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = base + 8'(i);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_n(input int n);
        bus.out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
        bus.out_ready = 1'b0;
    endtask

    logic [7:0] q[$];

    initial begin
        bus.in_data = 8'h00;
        idle();
        tick(); tick();
        chk("rst_valid",   32'(bus.out_valid), 32'd0);
        chk("rst_data",    32'(bus.out_data), 32'h00);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_ovr_cnt", 32'(bus.overrun_cnt), 32'd0);
        RST_N = 1'b1;
        tick();

        // 1-cycle FWFT latency and in-order pops
        bus.in_valid = 1'b1; bus.in_data = 8'h41;
        tick();
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_data",  32'(bus.out_data), 32'h41);
        bus.in_data = 8'h42; tick();
        bus.in_data = 8'h43; tick();
        bus.in_valid = 1'b0;
        chk("hold_data", 32'(bus.out_data), 32'h41);
        bus.out_ready = 1'b1;
        tick(); chk("pop1_data", 32'(bus.out_data), 32'h42);
        tick(); chk("pop2_data", 32'(bus.out_data), 32'h43);
        tick(); chk("pop3_valid", 32'(bus.out_valid), 32'd0);
        tick(); chk("empty_ready", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // fill to 16 then two dropped bytes
        push_n(16, 8'h00);
        bus.in_valid = 1'b1; bus.in_data = 8'hAA; tick();
        bus.in_data = 8'hBB; tick();
        bus.in_valid = 1'b0;
        chk("ovr_flag", 32'(bus.overrun), 32'd1);
        chk("ovr_cnt",  32'(bus.overrun_cnt), 32'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(bus.out_data), 32'(i));
            tick();
        end
        chk("drain_empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        do_flush();
        chk("flush_ovr", 32'(bus.overrun), 32'd0);

        // full + simultaneous push/pop
        push_n(16, 8'h00);
        bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("fpp_ovr",  32'(bus.overrun), 32'd0);
        chk("fpp_head", 32'(bus.out_data), 32'h01);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("fpp_seq_%0d", i), 32'(bus.out_data), 32'(i));
            tick();
        end
        chk("fpp_last",  32'(bus.out_data), 32'h55);
        tick();
        chk("fpp_empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // streaming with gaps; >32 pushes so the pointers wrap twice
        q.delete();
        for (int c = 0; c < 60; c++) begin
            bus.in_valid  = (c % 3) != 2;
            bus.in_data   = 8'(8'hC0 + c);
            bus.out_ready = (c % 4) != 0;
            chk("str_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            if (bus.out_ready && q.size() != 0) begin
                chk("str_data", 32'(bus.out_data), 32'(q[0]));
                void'(q.pop_front());
            end
            if (bus.in_valid) q.push_back(bus.in_data);
            tick();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            chk("str_dvalid", 32'(bus.out_valid), 32'd1);
            chk("str_ddata",  32'(bus.out_data), 32'(q[0]));
            void'(q.pop_front());
            tick();
        end
        chk("str_end", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // flush beats a same-cycle push and clears overrun
        push_n(16, 8'h10);
        bus.in_valid = 1'b1; bus.in_data = 8'h99; tick();
        bus.in_valid = 1'b0;
        pop_n(11);
        chk("pre_fl_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_fl_data",  32'(bus.out_data), 32'h1B);
        chk("pre_fl_ovr",   32'(bus.overrun), 32'd1);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h77;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("fl_valid",   32'(bus.out_valid), 32'd0);
        chk("fl_ovr",     32'(bus.overrun), 32'd0);
        chk("fl_ovr_cnt", 32'(bus.overrun_cnt), 32'd0);
        bus.out_ready = 1'b1;
        tick(); chk("fl_no77", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // asynchronous reset with 8 bytes buffered and overrun set
        push_n(16, 8'h80);
        bus.in_valid = 1'b1; bus.in_data = 8'hEE; tick();
        bus.in_valid = 1'b0;
        pop_n(8);
        chk("pre_rst_data", 32'(bus.out_data), 32'h88);
        chk("pre_rst_ovr",  32'(bus.overrun), 32'd1);
        #3 RST_N = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_ovr",   32'(bus.overrun), 32'd0);
        chk("arst_data",  32'(bus.out_data), 32'h00);
        chk("arst_cnt",   32'(bus.overrun_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
